serial_adder_ctrl: RTL and testbench

Bit-serial adder controller that shares one 1-bit adder slice (two half-adder stages plus a registered carry) between two requesters. It grants the slice round-robin, shifts the granted operand pair through it LSB-first over WIDTH cycles, and returns a registered WIDTH-bit sum and carry-out with a one-cycle done pulse. It sits between arithmetic clients and the shared adder datapath, trading latency for area.

---
 rtl/serial_adder_ctrl.sv | 105 ++++++++++
 tb/tb_serial_adder_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: round-robin arbitration between two requesters
// for one shared 1-bit adder slice, LSB-first over WIDTH cycles.
module serial_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0,
   input  logic [WIDTH-1:0] a0,
   input  logic [WIDTH-1:0] b0,
   input  logic             req1,
   input  logic [WIDTH-1:0] a1,
   input  logic [WIDTH-1:0] b1,
   output logic             busy,
   output logic             gnt,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

   state_t           state, state_nxt;
   logic             last, last_nxt, gnt_nxt;
   logic [WIDTH-1:0] sa, sb, sa_nxt, sb_nxt, sum_nxt;
   logic             c, c_nxt, cout_nxt;
   logic [CW-1:0]    cnt, cnt_nxt;
   logic             p, g, s, t;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         gnt   <= 1'b0;
         last  <= 1'b1;
         sa    <= '0;
         sb    <= '0;
         c     <= 1'b0;
         cnt   <= '0;
         sum   <= '0;
         cout  <= 1'b0;
      end else begin
         state <= state_nxt;
         gnt   <= gnt_nxt;
         last  <= last_nxt;
         sa    <= sa_nxt;
         sb    <= sb_nxt;
         c     <= c_nxt;
         cnt   <= cnt_nxt;
         sum   <= sum_nxt;
         cout  <= cout_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      gnt_nxt   = gnt;
      last_nxt  = last;
      sa_nxt    = sa;
      sb_nxt    = sb;
      c_nxt     = c;
      cnt_nxt   = cnt;
      sum_nxt   = sum;
      cout_nxt  = cout;
      // two half-adder stages on the current LSB
      p = sa[0] ^ sb[0];
      g = sa[0] & sb[0];
      s = p ^ c;
      t = p & c;
      case (state)
         IDLE: begin
            if (req0 || req1) begin
               gnt_nxt   = (req0 && req1) ? ~last : req1;
               sa_nxt    = gnt_nxt ? a1 : a0;
               sb_nxt    = gnt_nxt ? b1 : b0;
               c_nxt     = 1'b0;
               cnt_nxt   = '0;
               state_nxt = ADD;
            end
         end
         ADD: begin
            c_nxt              = g | t;
            sum_nxt            = sum >> 1;
            sum_nxt[WIDTH-1]   = s;
            sa_nxt             = sa >> 1;
            sb_nxt             = sb >> 1;
            cnt_nxt            = cnt + CW'(1);
            if (cnt == CW'(WIDTH - 1)) begin
               cout_nxt  = g | t;
               state_nxt = DONE;
            end
         end
         DONE: begin
            last_nxt  = gnt;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign busy = (state != IDLE);
   assign done = (state == DONE);

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench: three instances (WIDTH 8, 1, 16) share stimulus and are
// checked every cycle against a transaction-level model, plus literal checks.
module tb_serial_adder_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req0, req1;
   logic [15:0] a0, b0, a1, b1;

   logic       busy8, gnt8, done8, cout8;
   logic [7:0] sum8;
   logic       busy1, gnt1, done1, cout1;
   logic [0:0] sum1;
   logic       busy16, gnt16, done16, cout16;
   logic [15:0] sum16;

   int vec = 0;
   int err = 0;

   always #5 clk = ~clk;

   serial_adder_ctrl #(.WIDTH(8)) d8 (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .a0(a0[7:0]), .b0(b0[7:0]),
      .req1(req1), .a1(a1[7:0]), .b1(b1[7:0]),
      .busy(busy8), .gnt(gnt8), .done(done8), .sum(sum8), .cout(cout8));

   serial_adder_ctrl #(.WIDTH(1)) d1 (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .a0(a0[0:0]), .b0(b0[0:0]),
      .req1(req1), .a1(a1[0:0]), .b1(b1[0:0]),
      .busy(busy1), .gnt(gnt1), .done(done1), .sum(sum1), .cout(cout1));

   serial_adder_ctrl #(.WIDTH(16)) d16 (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .a0(a0), .b0(b0),
      .req1(req1), .a1(a1), .b1(b1),
      .busy(busy16), .gnt(gnt16), .done(done16), .sum(sum16), .cout(cout16));

   logic        obusy [3];
   logic        ognt  [3];
   logic        odone [3];
   logic        ocout [3];
   logic [15:0] osum  [3];

   always_comb begin
      obusy[0] = busy8;  ognt[0] = gnt8;  odone[0] = done8;  ocout[0] = cout8;  osum[0] = {8'h00, sum8};
      obusy[1] = busy1;  ognt[1] = gnt1;  odone[1] = done1;  ocout[1] = cout1;  osum[1] = {15'h0000, sum1};
      obusy[2] = busy16; ognt[2] = gnt16; odone[2] = done16; ocout[2] = cout16; osum[2] = sum16;
   end

   function automatic int wof(input int k);
      return (k == 0) ? 8 : (k == 1) ? 1 : 16;
   endfunction

   task automatic chk(input string nm, input logic [16:0] act, input logic [16:0] exp);
      vec++;
      if (act !== exp) begin
         err++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Transaction-level model: ph counts edges since the grant (0 = idle,
   // W+1 = done cycle); the result is plain a+b captured at the grant edge.
   int          ph [3];
   logic        mg [3], ml [3], mc [3];
   logic [16:0] mr [3];
   logic [15:0] ms [3];

   always @(posedge clk or negedge rst_n) begin
      logic [16:0] mask, opa, opb;
      for (int k = 0; k < 3; k++) begin
         mask = (17'h1 << wof(k)) - 17'h1;
         if (!rst_n) begin
            ph[k] = 0; mg[k] = 1'b0; ml[k] = 1'b1; ms[k] = '0; mc[k] = 1'b0; mr[k] = '0;
         end else if (ph[k] == 0) begin
            if (req0 || req1) begin
               mg[k] = (req0 && req1) ? !ml[k] : req1;
               opa   = {1'b0, (mg[k] ? a1 : a0)} & mask;
               opb   = {1'b0, (mg[k] ? b1 : b0)} & mask;
               mr[k] = opa + opb;
               ph[k] = 1;
            end
         end else if (ph[k] == wof(k) + 1) begin
            ph[k] = 0;
            ml[k] = mg[k];
         end else begin
            ph[k]++;
            if (ph[k] == wof(k) + 1) begin
               ms[k] = mr[k][15:0] & mask[15:0];
               mc[k] = mr[k][wof(k)];
            end
         end
      end
   end

   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("busy_w%0d", wof(k)), 17'(obusy[k]), 17'(ph[k] != 0));
         chk($sformatf("done_w%0d", wof(k)), 17'(odone[k]), 17'(ph[k] == wof(k) + 1));
         chk($sformatf("cout_w%0d", wof(k)), 17'(ocout[k]), 17'(mc[k]));
         if (ph[k] != 0)
            chk($sformatf("gnt_w%0d", wof(k)), 17'(ognt[k]), 17'(mg[k]));
         if (ph[k] == 0 || ph[k] == wof(k) + 1)
            chk($sformatf("sum_w%0d", wof(k)), 17'(osum[k]), 17'(ms[k]));
      end
   end

   // Returns at the negedge of the done cycle; j = edges after the grant edge.
   task automatic wait_done(input int k, input bit jit, output int j);
      j = 0;
      forever begin
         @(negedge clk);
         if (odone[k] === 1'b1) break;
         if (j >= 80) begin
            vec++; err++;
            $display("FAIL done_timeout_w%0d: got no done want done", wof(k));
            break;
         end
         @(posedge clk); #3;
         j++;
         if (jit) begin
            a0 = 16'($urandom); b0 = 16'($urandom);
            a1 = 16'($urandom); b1 = 16'($urandom);
         end
      end
   endtask

   task automatic step();
      @(posedge clk); #3;
   endtask

   initial begin
      int j, n;
      rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0;
      a0 = '0; b0 = '0; a1 = '0; b1 = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", 17'(busy8), 17'(0));
      chk("rst_done", 17'(done8), 17'(0));
      chk("rst_gnt",  17'(gnt8),  17'(0));
      chk("rst_sum",  17'(sum8),  17'(0));
      chk("rst_cout", 17'(cout8), 17'(0));

      // single request FF+01
      step();
      rst_n = 1'b1; req0 = 1'b1; a0 = 16'h00FF; b0 = 16'h0001;
      @(posedge clk);
      wait_done(0, 1'b0, j);
      chk("t1_latency", 17'(j), 17'(8));
      chk("t1_gnt", 17'(gnt8), 17'(0));
      chk("t1_sum", 17'(sum8), 17'(8'h00));
      chk("t1_cout", 17'(cout8), 17'(1));
      req0 = 1'b0;

      // simultaneous requests from reset release
      step();
      rst_n = 1'b0;
      req0 = 1'b1; req1 = 1'b1;
      a0 = 16'h0012; b0 = 16'h0034; a1 = 16'h00A5; b1 = 16'h005A;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      wait_done(0, 1'b0, j);
      chk("t2_gnt_a", 17'(gnt8), 17'(0));
      chk("t2_sum_a", 17'(sum8), 17'(8'h46));
      chk("t2_cout_a", 17'(cout8), 17'(0));
      n = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (busy8) break;
         n++;
      end
      chk("t2_idle_gap", 17'(n), 17'(1));
      wait_done(0, 1'b0, j);
      chk("t2_gnt_b", 17'(gnt8), 17'(1));
      chk("t2_sum_b", 17'(sum8), 17'(8'hFF));
      chk("t2_cout_b", 17'(cout8), 17'(0));

      // continuous contention with operands changing every cycle
      for (int i = 0; i < 6; i++) begin
         wait_done(0, 1'b1, j);
         chk($sformatf("t3_gnt_%0d", i), 17'(gnt8), 17'(i % 2));
      end
      req0 = 1'b0; req1 = 1'b0;
      repeat (25) @(posedge clk);

      // operand change after the grant edge
      step();
      req0 = 1'b1; a0 = 16'h000F; b0 = 16'h0001;
      @(posedge clk);
      #3 req0 = 1'b0;
      wait_done(0, 1'b1, j);
      chk("t4_sum", 17'(sum8), 17'(8'h10));
      chk("t4_cout", 17'(cout8), 17'(0));
      repeat (25) @(posedge clk);

      // reset at bit 4 of an operation
      step();
      req0 = 1'b1; a0 = 16'h00C3; b0 = 16'h00C3;
      @(posedge clk);
      #3 req0 = 1'b0;
      repeat (4) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("t5_busy", 17'(busy8), 17'(0));
      chk("t5_done", 17'(done8), 17'(0));
      chk("t5_sum", 17'(sum8), 17'(0));
      chk("t5_cout", 17'(cout8), 17'(0));
      chk("t5_busy16", 17'(busy16), 17'(0));
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b1; req1 = 1'b1; a1 = 16'h0033; b1 = 16'h0044;
      wait_done(0, 1'b0, j);
      chk("t5_gnt", 17'(gnt8), 17'(1));
      chk("t5_sum_after", 17'(sum8), 17'(8'h77));
      req1 = 1'b0;
      repeat (25) @(posedge clk);

      // WIDTH=1, 1+1
      step();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1; req0 = 1'b1; a0 = 16'h0001; b0 = 16'h0001;
      @(posedge clk);
      wait_done(1, 1'b0, j);
      chk("t6_latency_w1", 17'(j), 17'(1));
      chk("t6_sum_w1", 17'(sum1), 17'(0));
      chk("t6_cout_w1", 17'(cout1), 17'(1));
      req0 = 1'b0;

      // randomized sweep including corner operands
      for (int i = 0; i < 200; i++) begin
         int r, sel, hold;
         step();
         r = $urandom_range(0, 3);
         req0 = r[0]; req1 = r[1];
         sel = $urandom_range(0, 3);
         if (sel == 0) begin
            a0 = '0; b0 = '0; a1 = '0; b1 = '0;
         end else if (sel == 1) begin
            a0 = '1; b0 = '1; a1 = '1; b1 = '1;
         end else begin
            a0 = 16'($urandom); b0 = 16'($urandom);
            a1 = 16'($urandom); b1 = 16'($urandom);
         end
         hold = $urandom_range(1, 12);
         repeat (hold) @(posedge clk);
      end
      #3 req0 = 1'b0; req1 = 1'b0;
      repeat (25) @(posedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vec, err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish want finish by 500000");
      $fatal(1);
   end

endmodule
